// File: rtl/display_scan_controller.sv
// display_scan_controller
// Loads a binary value, converts it to three BCD digits with a serial
// shift-add-3 engine, and time-multiplexes the held result onto a shared
// digit bus with active-low anodes and leading-zero blanking.
module display_scan_controller #(
    parameter int WIDTH       = 10,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] entrada,
    input  logic             cargar,
    output logic             listo,
    output logic             overflow,
    output logic [3:0]       digito,
    output logic [3:0]       an
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] bitcnt;
    logic             ovf_pend;
    logic [WIDTH-1:0] shift_q;
    logic [11:0]      bcd_q;
    logic [11:0]      bcd_adj;
    logic [11:0]      disp_q;     // {hundreds, tens, units}
    logic             overflow_q;

    logic [REF_W-1:0] ref_q;
    logic [1:0]       idx_q;
    logic [3:0]       digito_q;
    logic [3:0]       an_q;
    logic [3:0]       nib;
    logic [3:0]       an_next;
    logic             blank_h;
    logic             blank_t;

    assign bcd_adj = add3(bcd_q);

    // Control FSM: load, WIDTH conversion cycles, one commit cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bitcnt     <= '0;
            ovf_pend   <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cargar) begin
                        bitcnt   <= '0;
                        ovf_pend <= (32'(entrada) > 32'd999);
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bitcnt <= bitcnt + 1'b1;
                    if (bitcnt == LAST_BIT) state <= COMMIT;
                end
                COMMIT: begin
                    disp_q     <= ovf_pend ? 12'hFFF : bcd_q;
                    overflow_q <= ovf_pend;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Double-dabble datapath: capture on load, adjust-then-shift while converting.
    always_ff @(posedge clk) begin
        if (state == IDLE && cargar) begin
            shift_q <= entrada;
            bcd_q   <= '0;
        end else if (state == CONVERT) begin
            {bcd_q, shift_q} <= {bcd_adj[10:0], shift_q, 1'b0};
        end
    end

    // Select the scanned nibble and its anode, blanking leading zeros unless overflowed.
    always_comb begin
        nib     = 4'd0;
        an_next = 4'b1111;
        blank_h = !overflow_q && (disp_q[11:8] == 4'd0);
        blank_t = blank_h && (disp_q[7:4] == 4'd0);
        case (idx_q)
            2'd0: begin
                nib     = disp_q[3:0];
                an_next = 4'b1110;
            end
            2'd1: begin
                nib     = disp_q[7:4];
                an_next = blank_t ? 4'b1111 : 4'b1101;
            end
            2'd2: begin
                nib     = disp_q[11:8];
                an_next = blank_h ? 4'b1111 : 4'b1011;
            end
            default: begin
                nib     = 4'd0;
                an_next = 4'b1111;
            end
        endcase
    end

    // Free-running refresh counter, scan index and registered digit/anode outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_q    <= '0;
            idx_q    <= 2'd0;
            digito_q <= 4'd0;
            an_q     <= 4'b1111;
        end else begin
            if (ref_q == REF_LAST) begin
                ref_q <= '0;
                idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            digito_q <= nib;
            an_q     <= an_next;
        end
    end

    assign listo    = (state == IDLE);
    assign overflow = overflow_q;
    assign digito   = digito_q;
    assign an       = an_q;

endmodule
